// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing for the 5-stage MIPS datapath: load-use bubbles, taken-branch
// flushes, freeze for the multi-cycle multiply unit, and a saturating stall counter.
module hazard_stall_controller #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      IFID_Instruction,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_RegisterRt,
    input  logic             EX_BranchTaken,
    input  logic             EX_MulStart,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             EXMEM_Bubble,
    output logic             MulBusy,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic {RUN, MUL} state_t;

    localparam logic [3:0] MUL_INIT  = 4'(MUL_LAT - 2);
    localparam bit         MUL_ENTER = (MUL_LAT > 2);

    state_t           state_q, state_d;
    logic [3:0]       mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic [5:0] opcode;
    logic [4:0] rs, rt;
    logic       rt_used, lu;
    logic       unused_ok;

    assign opcode    = IFID_Instruction[31:26];
    assign rs        = IFID_Instruction[25:21];
    assign rt        = IFID_Instruction[20:16];
    assign unused_ok = ^IFID_Instruction[15:0];

    // rt is a source only for R-type, beq/bne and the stores
    always_comb begin
        case (opcode)
            6'b000000, 6'b000100, 6'b000101,
            6'b101011, 6'b101001, 6'b101000: rt_used = 1'b1;
            default:                         rt_used = 1'b0;
        endcase
    end

    assign lu = IDEX_MemRead && (IDEX_RegisterRt != 5'd0) &&
                ((IDEX_RegisterRt == rs) || (rt_used && (IDEX_RegisterRt == rt)));

    always_comb begin
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IDEXWrite    = 1'b1;
        IDEX_Bubble  = 1'b0;
        IFID_Flush   = 1'b0;
        EXMEM_Bubble = 1'b0;
        MulBusy      = 1'b0;
        if (!Rst) begin
            if (state_q == MUL || (!EX_BranchTaken && EX_MulStart)) begin
                PCWrite      = 1'b0;
                IFIDWrite    = 1'b0;
                IDEXWrite    = 1'b0;
                EXMEM_Bubble = 1'b1;
                MulBusy      = 1'b1;
            end else if (EX_BranchTaken) begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end else if (lu) begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEX_Bubble = 1'b1;
            end
        end
    end

    // MulCnt holds the MUL-state cycles still to come; leave once it would reach zero
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            RUN: begin
                if (!EX_BranchTaken && EX_MulStart) begin
                    mul_cnt_d = MUL_INIT;
                    if (MUL_ENTER) state_d = MUL;
                end
            end
            MUL: begin
                mul_cnt_d = mul_cnt_q - 4'd1;
                if (mul_cnt_q <= 4'd1) begin
                    state_d   = RUN;
                    mul_cnt_d = 4'd0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!PCWrite && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= RUN;
            mul_cnt_q <= 4'd0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            stall_q   <= stall_d;
        end
    end

    assign StallCycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller; expected responses go through a
// scoreboard queue that a negedge monitor drains and compares.
module tb_hazard_stall_controller;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;

    // {PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble, IFID_Flush, EXMEM_Bubble, MulBusy}
    localparam logic [6:0] NORM = 7'b111_0000;
    localparam logic [6:0] LUS  = 7'b001_1000;
    localparam logic [6:0] BRF  = 7'b111_1100;
    localparam logic [6:0] FRZ  = 7'b000_0011;

    localparam logic [31:0] I_ADD   = 32'h0109_5020; // add $10,$8,$9
    localparam logic [31:0] I_ADD0  = 32'h0009_5020; // add $10,$0,$9
    localparam logic [31:0] I_ADDI  = 32'h2128_0005; // addi $8,$9,5
    localparam logic [31:0] I_SW    = 32'hAD28_0000; // sw $8,0($9)
    localparam logic [31:0] I_BEQ   = 32'h1128_0000; // beq $9,$8,0
    localparam logic [31:0] I_NOP   = 32'h0000_0000;

    typedef struct {
        logic [6:0]       ctl;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [31:0]      IFID_Instruction;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_RegisterRt;
    logic             EX_BranchTaken;
    logic             EX_MulStart;
    logic             PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble;
    logic             IFID_Flush, EXMEM_Bubble, MulBusy;
    logic [CNT_W-1:0] StallCycles;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    hazard_stall_controller #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .IFID_Instruction (IFID_Instruction),
        .IDEX_MemRead     (IDEX_MemRead),
        .IDEX_RegisterRt  (IDEX_RegisterRt),
        .EX_BranchTaken   (EX_BranchTaken),
        .EX_MulStart      (EX_MulStart),
        .PCWrite          (PCWrite),
        .IFIDWrite        (IFIDWrite),
        .IDEXWrite        (IDEXWrite),
        .IDEX_Bubble      (IDEX_Bubble),
        .IFID_Flush       (IFID_Flush),
        .EXMEM_Bubble     (EXMEM_Bubble),
        .MulBusy          (MulBusy),
        .StallCycles      (StallCycles)
    );

    always #5 Clk = ~Clk;

    // Drive one cycle of inputs just after the edge and queue what that cycle must show
    task automatic step(input string name, input logic rst, input logic [31:0] instr,
                        input logic mr, input logic [4:0] rt, input logic br,
                        input logic mul, input logic [6:0] ctl, input int cnt);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst              = rst;
        IFID_Instruction = instr;
        IDEX_MemRead     = mr;
        IDEX_RegisterRt  = rt;
        EX_BranchTaken   = br;
        EX_MulStart      = mul;
        e.ctl  = ctl;
        e.cnt  = CNT_W'(cnt);
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string name, input int cnt);
        step(name, 1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, NORM, cnt);
    endtask

    // Monitor: every cycle is an output cycle; pop and compare at the falling edge
    always @(negedge Clk) begin
        logic [6:0] act;
        exp_t       e;
        act = {PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble, IFID_Flush, EXMEM_Bubble, MulBusy};
        if (!Rst && EX_BranchTaken && EX_MulStart) begin
            n_miss++;
            $display("FAIL illegal_stim: EX_MulStart with EX_BranchTaken driven");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (act !== e.ctl || StallCycles !== e.cnt) begin
                n_miss++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                         e.name, act, StallCycles, e.ctl, e.cnt);
            end
        end
    end

    initial begin
        Rst = 1'b1; IFID_Instruction = I_NOP; IDEX_MemRead = 1'b0;
        IDEX_RegisterRt = 5'd0; EX_BranchTaken = 1'b0; EX_MulStart = 1'b1;

        step("rst0", 1'b1, I_NOP, 1'b0, 5'd0, 1'b0, 1'b1, NORM, 0);
        step("rst1", 1'b1, I_NOP, 1'b0, 5'd0, 1'b0, 1'b1, NORM, 0);
        idle("post_rst", 0);

        step("lu_add",   1'b0, I_ADD,  1'b1, 5'd8, 1'b0, 1'b0, LUS,  0);
        idle("lu_add_rel", 1);
        step("rt_zero",  1'b0, I_ADD0, 1'b1, 5'd0, 1'b0, 1'b0, NORM, 1);
        step("addi_rt",  1'b0, I_ADDI, 1'b1, 5'd8, 1'b0, 1'b0, NORM, 1);
        step("lu_sw",    1'b0, I_SW,   1'b1, 5'd8, 1'b0, 1'b0, LUS,  1);
        idle("lu_sw_rel", 2);
        step("lu_beq",   1'b0, I_BEQ,  1'b1, 5'd8, 1'b0, 1'b0, LUS,  2);
        idle("lu_beq_rel", 3);
        step("br_lu",    1'b0, I_ADD,  1'b1, 5'd8, 1'b1, 1'b0, BRF,  3);
        idle("br_after", 3);

        // single multiply with branch/LU noise during MUL
        step("mul_start", 1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b1, FRZ, 3);
        step("mul_c1",    1'b0, I_ADD, 1'b1, 5'd8, 1'b1, 1'b0, FRZ, 4);
        step("mul_c2",    1'b0, I_ADD, 1'b1, 5'd8, 1'b0, 1'b0, FRZ, 5);
        idle("mul_rel", 6);

        // back-to-back: second start on the release cycle
        step("b2b_start", 1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b1, FRZ, 6);
        step("b2b_c1",    1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, FRZ, 7);
        step("b2b_c2",    1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, FRZ, 8);
        step("b2b_again", 1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b1, FRZ, 9);
        step("b2b_c3",    1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, FRZ, 10);
        step("b2b_c4",    1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, FRZ, 11);
        idle("b2b_rel", 12);

        // reset during the second MUL cycle
        step("rm_start", 1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b1, FRZ, 12);
        step("rm_c1",    1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, FRZ, 13);
        step("rm_rst",   1'b1, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, NORM, 14);
        step("rm_run",   1'b0, I_NOP, 1'b0, 5'd0, 1'b1, 1'b0, BRF, 0);

        // continuous load-use drives the 4-bit counter into saturation
        for (int i = 0; i < 18; i++)
            step("sat", 1'b0, I_ADD, 1'b1, 5'd8, 1'b0, 1'b0, LUS, (i > 15) ? 15 : i);
        idle("sat_hold", 15);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge Clk);
        if (sb_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
